// File: rtl/usb_pkt_deframer.sv
// Frame hunter for the FTDI receive stream: verifies header and payload checksums,
// buffers the payload and replays a verified frame as one contiguous d/d_asserted burst.
module usb_pkt_deframer #(
    parameter int          MAX_LEN = 63,
    parameter int          TIMEOUT = 1023,
    parameter logic [7:0]  SYNC0   = 8'h5E,
    parameter logic [7:0]  SYNC1   = 8'h4D
) (
    input  logic       clk_ftdi,
    input  logic       n_rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] d,
    output logic       d_asserted,
    output logic       pkt_ok,
    output logic       hdr_err,
    output logic       dat_err,
    output logic       tmo_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [3:0] {
        HUNT0, HUNT1, ADDR, CTRL, LEN, HCS, DATA, DCS, EMIT, GAP
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      addr_q, addr_d, ctrl_q, ctrl_d, len_q, len_d, sum_q, sum_d;
    logic [6:0]      idx_q, idx_d, burstCnt_q, burstCnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      d_q, d_d;
    logic            dAsserted_q, dAsserted_d, pktOk_q, pktOk_d;
    logic            hdrErr_q, hdrErr_d, datErr_q, datErr_d, tmoErr_q, tmoErr_d;
    logic            writeEn;

    logic [7:0]      payloadMem [0:MAX_LEN-1];

    logic            accept, inFrame, tmoHit, hdrBad, dcsBad, dataLast;
    logic [7:0]      hdrSum;
    logic [6:0]      burstLast;
    logic [AW-1:0]   rdIdx;

    assign accept    = rx_valid & rx_ready;
    assign inFrame   = state_q inside {HUNT1, ADDR, CTRL, LEN, HCS, DATA, DCS};
    assign tmoHit    = inFrame && !accept && (tmo_q == TW'(TIMEOUT - 1));
    assign hdrSum    = addr_q + ctrl_q + len_q;
    assign hdrBad    = (rx_byte != hdrSum) || (len_q > 8'(MAX_LEN));
    assign dcsBad    = (rx_byte != sum_q);
    assign dataLast  = ({1'b0, idx_q} == (len_q - 8'd1));
    assign burstLast = len_q[6:0] + 7'd1;
    assign rdIdx     = AW'(burstCnt_d - 7'd2);

    always_ff @(posedge clk_ftdi) begin
        if (!n_rst) begin
            state_q     <= HUNT0;
            addr_q      <= '0;
            ctrl_q      <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            burstCnt_q  <= '0;
            tmo_q       <= '0;
            d_q         <= '0;
            dAsserted_q <= 1'b0;
            pktOk_q     <= 1'b0;
            hdrErr_q    <= 1'b0;
            datErr_q    <= 1'b0;
            tmoErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ctrl_q      <= ctrl_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            burstCnt_q  <= burstCnt_d;
            tmo_q       <= tmo_d;
            d_q         <= d_d;
            dAsserted_q <= dAsserted_d;
            pktOk_q     <= pktOk_d;
            hdrErr_q    <= hdrErr_d;
            datErr_q    <= datErr_d;
            tmoErr_q    <= tmoErr_d;
        end
    end

    always_ff @(posedge clk_ftdi) begin
        if (writeEn)
            payloadMem[idx_q[AW-1:0]] <= rx_byte;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ctrl_d     = ctrl_q;
        len_d      = len_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        burstCnt_d = burstCnt_q;
        writeEn    = 1'b0;
        tmo_d      = (inFrame && !accept) ? tmo_q + TW'(1) : '0;
        case (state_q)
            HUNT0: if (accept && rx_byte == SYNC0) state_d = HUNT1;
            HUNT1: if (accept) begin
                if (rx_byte == SYNC1)      state_d = ADDR;
                else if (rx_byte != SYNC0) state_d = HUNT0;
            end
            ADDR: if (accept) begin addr_d = rx_byte; state_d = CTRL; end
            CTRL: if (accept) begin ctrl_d = rx_byte; state_d = LEN;  end
            LEN:  if (accept) begin len_d  = rx_byte; state_d = HCS;  end
            HCS: if (accept) begin
                idx_d = '0;
                sum_d = '0;
                if (hdrBad)            state_d = HUNT0;
                else if (len_q == 8'd0) state_d = DCS;
                else                   state_d = DATA;
            end
            DATA: if (accept) begin
                writeEn = 1'b1;
                sum_d   = sum_q + rx_byte;
                idx_d   = idx_q + 7'd1;
                if (dataLast) state_d = DCS;
            end
            DCS: if (accept) begin
                burstCnt_d = '0;
                state_d    = dcsBad ? HUNT0 : EMIT;
            end
            EMIT: begin
                if (burstCnt_q == burstLast) state_d = GAP;
                else                         burstCnt_d = burstCnt_q + 7'd1;
            end
            GAP:     state_d = HUNT0;
            default: state_d = HUNT0;
        endcase
        if (tmoHit) begin
            state_d = HUNT0;
            tmo_d   = '0;
        end
    end

    // Burst outputs are computed from the next state so they line up with EMIT cycles.
    always_comb begin
        rx_ready    = (state_q != EMIT) && (state_q != GAP);
        d_d         = '0;
        dAsserted_d = 1'b0;
        pktOk_d     = 1'b0;
        hdrErr_d    = (state_q == HCS) && accept && hdrBad;
        datErr_d    = (state_q == DCS) && accept && dcsBad;
        tmoErr_d    = tmoHit;
        if (state_d == EMIT) begin
            dAsserted_d = 1'b1;
            pktOk_d     = (burstCnt_d == burstLast);
            case (burstCnt_d)
                7'd0:    d_d = ctrl_q;
                7'd1:    d_d = addr_q;
                default: d_d = payloadMem[rdIdx];
            endcase
        end
    end

    assign d          = d_q;
    assign d_asserted = dAsserted_q;
    assign pkt_ok     = pktOk_q;
    assign hdr_err    = hdrErr_q;
    assign dat_err    = datErr_q;
    assign tmo_err    = tmoErr_q;

endmodule

// File: doc/usb_pkt_deframer.md
Name: usb_pkt_deframer

Overview:
Upstream stage of the USB control-register file. Takes raw bytes from the FTDI receive FIFO interface on clk_ftdi and hunts for frames. It checks the header and payload checksums and buffers the whole payload. Only after the frame is verified does it replay it as one contiguous d/d_asserted burst, so register and CCW writes are all-or-nothing.

Parameters:
MAX_LEN, 63, largest accepted payload length in bytes; the buffer holds MAX_LEN bytes.
TIMEOUT, 1023, maximum idle clk_ftdi cycles allowed between two bytes inside a frame.
SYNC0, 8'h5E, first sync byte.
SYNC1, 8'h4D, second sync byte.

Ports:
clk_ftdi  in  1  FTDI-domain clock; the only clock.
n_rst  in  1  synchronous active-low reset, sampled on the rising edge of clk_ftdi.
rx_byte  in  8  received byte.
rx_valid  in  1  rx_byte is valid this cycle.
rx_ready  out  1  deframer accepts a byte this cycle; a byte transfers when rx_valid & rx_ready.
d  out  8  replayed byte to the register file.
d_asserted  out  1  high for every cycle of a replay burst, low otherwise.
pkt_ok  out  1  one-cycle pulse on the last burst cycle.
hdr_err  out  1  one-cycle pulse: header checksum mismatch, or LEN > MAX_LEN.
dat_err  out  1  one-cycle pulse: payload checksum mismatch.
tmo_err  out  1  one-cycle pulse: inter-byte timeout inside a frame.

Behaviour:
- Frame on the wire: SYNC0, SYNC1, ADDR, CTRL, LEN, HCS, DATA[0..LEN-1], DCS.
- HCS = (ADDR + CTRL + LEN) mod 256.
- DCS = (sum of DATA) mod 256; with LEN=0, DCS must be 8'h00.
- Reset (n_rst=0 at a clock edge):
  - state = HUNT0; rx_ready=1; d=0; d_asserted=0; all pulses=0; counters=0.
  - This holds even mid-frame or mid-burst; the burst is truncated immediately.
- States: HUNT0, HUNT1, ADDR, CTRL, LEN, HCS, DATA, DCS, EMIT, GAP.
- Header states advance only on an accepted byte:
  - HUNT0: SYNC0 -> HUNT1; any other byte stays in HUNT0.
  - HUNT1: SYNC1 -> ADDR; SYNC0 stays in HUNT1; any other byte -> HUNT0.
  - ADDR, CTRL, LEN: latch the byte and advance to the next state.
  - HCS: on a mismatch, or if LEN > MAX_LEN, pulse hdr_err and go to HUNT0. Otherwise go to DATA, or to DCS if LEN=0.
- DATA:
  - Each byte is written to buffer[idx] and added to the running sum; idx increments.
  - When idx reaches LEN-1 and that byte is accepted, go to DCS.
- DCS: on a mismatch, pulse dat_err and go to HUNT0. On a match, go to EMIT.
- rx_ready = 1 in HUNT0 through DCS, and 0 in EMIT and GAP.
- EMIT:
  - Lasts LEN+2 consecutive cycles with d_asserted=1.
  - Order of d: CTRL, ADDR, buffer[0..LEN-1].
  - d and d_asserted are registered; the first burst cycle is the cycle after the DCS byte is accepted.
  - pkt_ok is high on the last burst cycle.
- GAP: exactly one cycle with d_asserted=0 and rx_ready=0, then HUNT0. This guarantees the register file's packer returns to idle between bursts.
- Timeout:
  - In states HUNT1 through DCS, a counter counts cycles without an accepted byte.
  - When it reaches TIMEOUT: pulse tmo_err, go to HUNT0, clear the counter.
  - The counter clears on every accepted byte and in every other state.
- Pulse priority: all error pulses and pkt_ok are mutually exclusive by construction, since they come from different states.
- Width rules: idx and the burst counter are 7 bits; checksums are 8-bit with wrap-around.
- Buffer: inferred RAM or register array of MAX_LEN x 8. A write in DATA and a read in EMIT never overlap.

Test Plan:
- STR write: 5E 4D 00 00 08 08 01 02 03 04 05 06 07 08 24 -> 10-cycle burst d = 00,00,01..08 with d_asserted=1 throughout, pkt_ok on cycle 10, then one idle cycle.
- Zero length: 5E 4D 0A 03 00 0D 00 -> 2-cycle burst d = 03,0A; pkt_ok on cycle 2; with LEN=0, DCS=00 is required.
- Bad DCS: same frame as the first case but DCS=25 -> dat_err pulse, d_asserted never rises, next valid frame accepted normally.
- Length check: LEN=0x40 with a correct HCS -> hdr_err. Also HCS off by one -> hdr_err, return to HUNT0.
- Resync: stream AA 5E 5E 4D followed by a valid frame body -> frame accepted. Also a stall of TIMEOUT cycles after the ADDR byte -> tmo_err, then a fresh frame accepted.
- Reset mid-burst: n_rst=0 on burst cycle 4 -> next edge gives d_asserted=0, rx_ready=1, state HUNT0, with no pkt_ok.
